square_root_engine: RTL

- Parametrised successor to the fixed 8-bit square root finder: computes the integer square root of a WIDTH-bit unsigned radicand.
- Uses the digit-by-digit (restoring, radix-4) method, one root bit per clock, with a start/busy/done handshake.
- Adds floor/round-to-nearest mode, remainder output and a perfect-square flag.
- Sits between the switch/operand capture logic and the base conversion / seven-segment display path.

---
 rtl/square_root_engine.sv | 115 +++++++++++
 1 files changed

// File: rtl/square_root_engine.sv
// rtl/square_root_engine.sv - radix-4 restoring integer square root, one root bit per clock
module square_root_engine #(
  parameter int WIDTH = 16,
  parameter int HALF  = WIDTH / 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [WIDTH-1:0]  alpha,
  output logic              busy,
  output logic              done,
  output logic [HALF:0]     root,
  output logic [HALF:0]     remainder,
  output logic              exact
);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4 || WIDTH > 32 || HALF != WIDTH / 2) begin : g_bad_width
      $error("square_root_engine: WIDTH must be even in 4..32 and HALF must equal WIDTH/2");
    end
  endgenerate

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_alpha;
  logic             r_mode;
  logic [HALF-1:0]  r_wroot;
  logic [HALF+1:0]  r_wrem;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_shifted;
  logic [HALF+3:0]  w_t;
  logic [HALF+3:0]  w_d;
  logic [HALF+3:0]  w_diff;
  logic             w_ge;
  logic [HALF+1:0]  w_rem_nxt;
  logic [HALF-1:0]  w_root_nxt;
  logic             w_round_up;
  logic [HALF:0]    w_root_out;

  // Two extra guard bits on t/d keep the compare exact before truncating back.
  assign w_shifted  = r_alpha >> {r_cnt, 1'b0};
  assign w_t        = {r_wrem, w_shifted[1:0]};
  assign w_d        = {2'b00, r_wroot, 2'b01};
  assign w_diff     = w_t - w_d;
  assign w_ge       = (w_t >= w_d);
  assign w_rem_nxt  = w_ge ? w_diff[HALF+1:0] : w_t[HALF+1:0];
  assign w_root_nxt = {r_wroot[HALF-2:0], w_ge};
  assign w_round_up = r_mode & (r_wrem > {2'b00, r_wroot});
  assign w_root_out = {1'b0, r_wroot} + {{HALF{1'b0}}, w_round_up};

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_RUN;
      S_RUN:    if (r_cnt == '0) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_alpha   <= '0;
      r_mode    <= 1'b0;
      r_wroot   <= '0;
      r_wrem    <= '0;
      r_cnt     <= '0;
      root      <= '0;
      remainder <= '0;
      exact     <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_alpha <= alpha;
            r_mode  <= mode;
            r_wroot <= '0;
            r_wrem  <= '0;
            r_cnt   <= CW'(HALF - 1);
          end
        end
        S_RUN: begin
          r_wrem  <= w_rem_nxt;
          r_wroot <= w_root_nxt;
          r_cnt   <= r_cnt - CW'(1);
        end
        S_FINISH: begin
          remainder <= r_wrem[HALF:0];
          exact     <= (r_wrem == '0);
          root      <= w_root_out;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
